// File: rtl/ctrlport_if_timeout_responder_if.sv
// ctrlport_if: CtrlPort request/response bundle.
//   master modport: drives the request fields, receives the response.
//   slave modport : receives the request fields, drives the response.
interface ctrlport_if;
  logic        req_wr;
  logic        req_rd;
  logic [19:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_byte_en;
  logic        req_has_time;
  logic [63:0] req_time;
  logic        resp_ack;
  logic [1:0]  resp_status;
  logic [31:0] resp_data;

  modport master (
    output req_wr, req_rd, req_addr, req_data, req_byte_en, req_has_time, req_time,
    input  resp_ack, resp_status, resp_data
  );

  modport slave (
    input  req_wr, req_rd, req_addr, req_data, req_byte_en, req_has_time, req_time,
    output resp_ack, resp_status, resp_data
  );
endinterface

// File: rtl/ctrlport_if_timeout_responder.sv
// ctrlport_if_timeout_responder: single-outstanding CtrlPort guard.
// Forwards each upstream request downstream and returns the downstream response one
// cycle later. If nothing acknowledges within TIMEOUT cycles, an error ack is generated.
//   ctrlport_clk  : clock
//   ctrlport_rst  : synchronous active-high reset
//   s_ctrlport    : upstream side (request in, response out)
//   m_ctrlport    : downstream side (request out, response in)
//   timeout_stb   : one-cycle pulse with each generated ack
//   timeout_count : generated acks since reset, saturating at 16'hFFFF
module ctrlport_if_timeout_responder #(
  parameter int unsigned TIMEOUT        = 1024,
  parameter logic [1:0]  TIMEOUT_STATUS = 2'b01
) (
  input  logic        ctrlport_clk,
  input  logic        ctrlport_rst,
  ctrlport_if.slave   s_ctrlport,
  ctrlport_if.master  m_ctrlport,
  output logic        timeout_stb,
  output logic [15:0] timeout_count
);

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ack_q, ack_d;
  logic [1:0]  status_q, status_d;
  logic [31:0] data_q, data_d;
  logic        stb_q, stb_d;
  logic [15:0] tcount_q, tcount_d;
  logic        fwd_en;

  // Requests pass only while idle; anything arriving during WAIT is a violation and is masked.
  assign fwd_en = (state_q == StIdle) && !ctrlport_rst;

  assign m_ctrlport.req_wr       = s_ctrlport.req_wr && fwd_en;
  assign m_ctrlport.req_rd       = s_ctrlport.req_rd && fwd_en;
  assign m_ctrlport.req_addr     = s_ctrlport.req_addr;
  assign m_ctrlport.req_data     = s_ctrlport.req_data;
  assign m_ctrlport.req_byte_en  = s_ctrlport.req_byte_en;
  assign m_ctrlport.req_has_time = s_ctrlport.req_has_time;
  assign m_ctrlport.req_time     = s_ctrlport.req_time;

  assign s_ctrlport.resp_ack    = ack_q;
  assign s_ctrlport.resp_status = status_q;
  assign s_ctrlport.resp_data   = data_q;
  assign timeout_stb            = stb_q;
  assign timeout_count          = tcount_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ack_d    = 1'b0;
    status_d = 2'b00;
    data_d   = 32'h0;
    stb_d    = 1'b0;
    tcount_d = tcount_q;
    unique case (state_q)
      StIdle: begin
        // A downstream ack seen here is stale or unsolicited and is dropped.
        if (s_ctrlport.req_wr || s_ctrlport.req_rd) begin
          state_d = StWait;
          cnt_d   = 16'h0;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 16'h1;
        // A real ack wins over a timeout landing in the same cycle.
        if (m_ctrlport.resp_ack) begin
          ack_d    = 1'b1;
          status_d = m_ctrlport.resp_status;
          data_d   = m_ctrlport.resp_data;
          state_d  = StIdle;
        end else if (cnt_q == TimeoutLast) begin
          ack_d    = 1'b1;
          status_d = TIMEOUT_STATUS;
          stb_d    = 1'b1;
          if (tcount_q != 16'hFFFF) begin
            tcount_d = tcount_q + 16'h1;
          end
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ctrlport_clk) begin
    if (ctrlport_rst) begin
      state_q  <= StIdle;
      cnt_q    <= 16'h0;
      ack_q    <= 1'b0;
      status_q <= 2'b00;
      data_q   <= 32'h0;
      stb_q    <= 1'b0;
      tcount_q <= 16'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      status_q <= status_d;
      data_q   <= data_d;
      stb_q    <= stb_d;
      tcount_q <= tcount_d;
    end
  end

endmodule

// File: doc/ctrlport_if_timeout_responder.md
# ctrlport_if_timeout_responder

Single-outstanding CtrlPort guard that sits directly upstream of a bank of address windows and their register slaves. It forwards each request to the downstream bus and returns the downstream response to the master. If no downstream slave acknowledges within a bounded number of cycles, it generates the acknowledge itself with an error status. This guarantees that every CtrlPort request is answered, even when the address falls outside every window.

## Interface

Parameters:

- TIMEOUT, 1024: cycles after the request cycle during which a downstream ack is accepted; legal range 2 to 65535.
- TIMEOUT_STATUS, 2'b01: value driven on resp.status for a generated ack (CMDERR).

Ports:

- ctrlport_clk  input  1  clock; every port is synchronous to it.
- ctrlport_rst  input  1  synchronous, active-high reset.
- s_ctrlport  ctrlport_if.slave  —  upstream request in, response out.
- m_ctrlport  ctrlport_if.master  —  request out toward the address windows, response in.
- timeout_stb  output  1  one-cycle pulse in the cycle a generated ack is driven.
- timeout_count  output  16  number of generated acks since reset; saturates at 16'hFFFF.

## Operation

- The block has two states, IDLE and WAIT. Reset enters IDLE.
- Request path is combinational:
  - m_ctrlport.req equals s_ctrlport.req in every field, except wr and rd.
  - m req.wr = s req.wr && (state == IDLE). m req.rd is formed the same way.
- IDLE, when s req.wr or s req.rd is set:
  - Forward the request.
  - Clear the counter.
  - Go to WAIT.
- WAIT, on each cycle:
  - The counter increments.
  - If m resp.ack is set, register ack=1 together with m resp.status and m resp.data. Drive them to s_ctrlport.resp on the next cycle, then return to IDLE.
  - If m resp.ack is clear and the counter equals TIMEOUT-1, register a generated response (ack=1, status=TIMEOUT_STATUS, data=0). Pulse timeout_stb in the output cycle, increment timeout_count, and return to IDLE.
- A master ack and the timeout in the same cycle: the master ack wins. timeout_stb stays low and timeout_count is unchanged.
- m resp.ack while in IDLE is discarded. This includes:
  - a late ack from a request that already timed out;
  - an ack in the same cycle as a new request.
- A new upstream request while in WAIT is a protocol violation. It is masked and never forwarded, and no response is generated for it.
- s_ctrlport.resp fields are registered:
  - ack is high for exactly one cycle per accepted request.
  - status and data hold their value only while ack is high and are 0 otherwise.
- The counter width is 16 bits. It never wraps within one transaction, because TIMEOUT is at most 65535.

## Timing

- Request latency is 0 cycles, from s to m, combinational.
- Response latency is 1 cycle: m ack at cycle N gives s ack at cycle N+1.
- For a request accepted at cycle T0:
  - A downstream ack is honored at cycles T0+1 through T0+TIMEOUT.
  - If none arrives, s ack with TIMEOUT_STATUS is driven at T0+TIMEOUT+1.
- The earliest next forwarded request is in the same cycle as the s ack, because the state is IDLE again.
- Reset values: s resp.ack=0, status=0, data=0; timeout_stb=0; timeout_count=0; state=IDLE; counter=0. m req.wr and m req.rd are 0 whenever reset is active.
- Reset asserted while in WAIT:
  - The transaction is abandoned and no ack is issued.
  - A downstream ack arriving after reset is discarded, because the state is IDLE.

## Test plan

- **Normal read.** Read of addr 0x10. The downstream acks 3 cycles later with status 00 and data 0xDEADBEEF. Required: s ack 1 cycle after the downstream ack, with status 00 and data 0xDEADBEEF; timeout_stb stays 0.
- **Unclaimed write.** TIMEOUT=8, write to an unmapped addr, no downstream ack. Required: s ack at T0+9 with status 01 and data 0; timeout_stb high in that cycle; timeout_count=1.
- **Boundary.** TIMEOUT=8.
  - Downstream ack at exactly T0+8 is forwarded with status 00 and no timeout.
  - Downstream ack at T0+9 is discarded: s sees only the generated error ack, and timeout_count increments.
- **Violation and late ack.**
  - A second request 2 cycles into WAIT is not visible on m (wr=rd=0), and exactly one s ack results.
  - A late ack after a timeout, arriving in IDLE, produces no s ack.
- **Reset.**
  - ctrlport_rst asserted mid-WAIT: all outputs 0 next cycle and timeout_count=0.
  - A downstream ack after reset produces no s ack.
  - The next request is forwarded normally.
- **Saturation.** Preload 65535 generated timeouts; a further timeout keeps timeout_count at 16'hFFFF while timeout_stb still pulses.
